ysyx_25040109_csr_ctrl: RTL
===========================

Name: ysyx_25040109_csr_ctrl

Overview:
- Initiator side of the register-file CSR port: drives csr_we, csr_addr and csr_wdata, and consumes csr_rdata, mepc and mtvec.
- Executes Zicsr read-modify-write ops (CSRRW, CSRRS, CSRRC), ECALL trap entry and MRET return as multi-cycle sequences. The register file has a single CSR write port, so trap entry is serialised.
- Sits between the decode/execute stage (valid/ready request) and the register file. Also produces the GPR writeback and the PC redirect.

Parameters:
- DATA_WIDTH, 32, CSR/GPR/PC data width
- ADDR_WIDTH, 5, GPR index width
- MCAUSE_ECALL, 32'd11, value written to mcause on ECALL (M-mode)
- CSR_MEPC, 12'h341, mepc address
- CSR_MCAUSE, 12'h342, mcause address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET, others illegal
- req_csr  in  12  target CSR address
- req_src  in  DATA_WIDTH  rs1 value (or zimm zero-extended)
- req_src_zero  in  1  rs1 field/zimm is zero; suppresses the write for CSRRS/CSRRC
- req_rd  in  ADDR_WIDTH  destination GPR
- req_pc  in  DATA_WIDTH  PC of the instruction
- csr_we  out  1  CSR write enable to the register file
- csr_addr  out  12  CSR address to the register file
- csr_wdata  out  DATA_WIDTH  CSR write data
- csr_rdata  in  DATA_WIDTH  combinational CSR read data for csr_addr
- mepc_in  in  DATA_WIDTH  current mepc
- mtvec_in  in  DATA_WIDTH  current mtvec
- gpr_wen, gpr_waddr, gpr_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  GPR writeback
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  DATA_WIDTH  jump target
- done  out  1  one-cycle pulse on the last cycle of every accepted request

Behaviour:
- Reset: state=IDLE, request latch cleared. All outputs are Moore, decoded from state and latch.
  - req_ready=1 out of reset.
  - csr_we, gpr_wen, redirect_valid, done = 0.
  - csr_addr, csr_wdata, gpr_*, redirect_pc = 0.
- Acceptance: on req_valid && req_ready at edge N, all req_* fields are latched and the FSM leaves IDLE. req_ready=0 until the FSM returns to IDLE. Requests presented while busy are ignored.
- States: IDLE, RD, WR, T_EPC, T_CAUSE, T_JMP, RET, ILL.
- CSR ops: IDLE -> RD -> WR -> IDLE.
  - RD: csr_addr=latched csr, csr_we=0. old <= csr_rdata.
  - WR: csr_addr=latched csr. new = src (RW), old|src (RS), old&~src (RC).
  - WR: csr_we=1 unless (op is RS/RC and src_zero). CSRRW always writes.
  - WR: gpr_wen = (rd!=0), gpr_waddr=rd, gpr_wdata=old, done=1.
  - Latency: 2 cycles from acceptance to done.
- ECALL: IDLE -> T_EPC -> T_CAUSE -> T_JMP -> IDLE.
  - T_EPC: csr_we=1, csr_addr=CSR_MEPC, wdata=pc.
  - T_CAUSE: csr_we=1, csr_addr=CSR_MCAUSE, wdata=MCAUSE_ECALL.
  - T_JMP: redirect_valid=1, redirect_pc=mtvec_in sampled that cycle, done=1. No GPR write.
- MRET: IDLE -> RET -> IDLE. RET: redirect_valid=1, redirect_pc=mepc_in, done=1. No CSR or GPR write.
- Illegal op: IDLE -> ILL -> IDLE. ILL: done=1 only, no side effects.
- mstatus is never modified by ECALL/MRET; privilege stacking is out of scope.
- Unsupported CSR addresses: the sequence runs unchanged. The register file returns 0 and drops the write.
- Back-to-back: req_ready rises the cycle after done. Minimum spacing is 3 cycles per CSR op and 4 per ECALL.
- Reset mid-operation: any state -> IDLE on the same edge. No write or redirect is issued in or after the reset cycle.
- rd=0: CSR write still occurs, GPR write suppressed.

Decomposition:
- Shared package: op encodings, FSM state encoding, CSR address constants (mstatus/mtvec/mepc/mcause) shared with the register file, MCAUSE_ECALL.
- One natural sub-module: ysyx_25040109_csr_alu, combinational RW/RS/RC new-value compute plus write-suppress flag.

Test Plan:
- CSRRW csr=0x305, src=0x8000_0100, rd=5, mtvec=0x0 -> RD then WR; csr_we=1 with wdata 0x8000_0100; gpr x5<=0x0; done 2 cycles after accept.
- CSRRS csr=0x300, mstatus=0x1800, src=0x8, rd=6 -> wdata 0x1808, x6<=0x1800. Repeat with src_zero=1 -> csr_we stays 0, x6<=0x1800.
- CSRRC csr=0x342, old=0xF, src=0x5, rd=0 -> wdata 0xA; gpr_wen=0.
- ECALL pc=0x8000_0010, mtvec=0x8000_0200 -> mepc<=0x8000_0010, then mcause<=11, then redirect 0x8000_0200; done 3 cycles after accept; req_ready low throughout.
- MRET with mepc=0x8000_0014 -> redirect_valid 1 cycle, pc 0x8000_0014; a req_valid held during the busy cycle is accepted only after done.
- rst asserted in T_CAUSE -> next cycle IDLE, csr_we=0, redirect_valid never asserted; op=7 -> single done pulse, no writes.

Source files
------------

// File: rtl/ysyx_25040109_csr_ctrl_pkg.sv
// Shared encodings for the CSR sequencer and the CSR register file:
// request opcodes, sequencer states and machine-mode CSR addresses.
package ysyx_25040109_csr_ctrl_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam int ECALL_CAUSE = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_T_EPC,
        S_T_CAUSE,
        S_T_JMP,
        S_RET,
        S_ILL
    } state_e;

endpackage

// File: rtl/ysyx_25040109_csr_alu.sv
// Zicsr new-value compute and write-enable for the read-modify-write
// ops; set/clear with a zero source leave the CSR untouched.
module ysyx_25040109_csr_alu
    import ysyx_25040109_csr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] old_val,
    input  logic [DATA_WIDTH-1:0] src,
    input  logic                  src_zero,
    output logic [DATA_WIDTH-1:0] new_val,
    output logic                  wr_en
);

    always_comb begin
        new_val = src;
        wr_en   = 1'b0;
        unique case (1'b1)
            op == OP_CSRRW: begin
                new_val = src;
                wr_en   = 1'b1;
            end
            op == OP_CSRRS: begin
                new_val = old_val | src;
                wr_en   = !src_zero;
            end
            op == OP_CSRRC: begin
                new_val = old_val & ~src;
                wr_en   = !src_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_csr_ctrl.sv
// CSR access sequencer: Zicsr RMW, serialised ECALL trap entry and MRET,
// driving the single CSR write port, GPR writeback and PC redirect.
module ysyx_25040109_csr_ctrl
    import ysyx_25040109_csr_ctrl_pkg::*;
#(
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     ADDR_WIDTH   = 5,
    parameter logic [DATA_WIDTH-1:0]  MCAUSE_ECALL = DATA_WIDTH'(ECALL_CAUSE),
    parameter logic [11:0]            CSR_MEPC     = ADDR_MEPC,
    parameter logic [11:0]            CSR_MCAUSE   = ADDR_MCAUSE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [11:0]           req_csr,
    input  logic [DATA_WIDTH-1:0] req_src,
    input  logic                  req_src_zero,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    input  logic [DATA_WIDTH-1:0] req_pc,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  done
);

    state_e state, state_nxt;

    logic [2:0]            op_q;
    logic [11:0]           csr_q;
    logic [DATA_WIDTH-1:0] src_q;
    logic                  zero_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] old_q;

    logic [DATA_WIDTH-1:0] alu_new;
    logic                  alu_we;
    logic                  accept;
    logic                  csr_we_d;
    logic                  gpr_wen_d;
    logic                  redir_d;
    logic                  done_d;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    ysyx_25040109_csr_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op       (op_q),
        .old_val  (old_q),
        .src      (src_q),
        .src_zero (zero_q),
        .new_val  (alu_new),
        .wr_en    (alu_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            csr_q  <= '0;
            src_q  <= '0;
            zero_q <= 1'b0;
            rd_q   <= '0;
            pc_q   <= '0;
            old_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= req_op;
                csr_q  <= req_csr;
                src_q  <= req_src;
                zero_q <= req_src_zero;
                rd_q   <= req_rd;
                pc_q   <= req_pc;
            end
            if (state == S_RD) begin
                old_q <= csr_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (1'b1)
                        req_op == OP_CSRRW,
                        req_op == OP_CSRRS,
                        req_op == OP_CSRRC: state_nxt = S_RD;
                        req_op == OP_ECALL: state_nxt = S_T_EPC;
                        req_op == OP_MRET:  state_nxt = S_RET;
                        default:            state_nxt = S_ILL;
                    endcase
                end
            end
            S_RD:      state_nxt = S_WR;
            S_T_EPC:   state_nxt = S_T_CAUSE;
            S_T_CAUSE: state_nxt = S_T_JMP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        csr_we_d    = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        gpr_wen_d   = 1'b0;
        gpr_waddr   = '0;
        gpr_wdata   = '0;
        redir_d     = 1'b0;
        redirect_pc = '0;
        done_d      = 1'b0;
        unique case (state)
            S_RD: csr_addr = csr_q;
            S_WR: begin
                csr_addr  = csr_q;
                csr_wdata = alu_new;
                csr_we_d  = alu_we;
                gpr_wen_d = (rd_q != '0);
                gpr_waddr = rd_q;
                gpr_wdata = old_q;
                done_d    = 1'b1;
            end
            S_T_EPC: begin
                csr_we_d  = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = pc_q;
            end
            S_T_CAUSE: begin
                csr_we_d  = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = MCAUSE_ECALL;
            end
            S_T_JMP: begin
                redir_d     = 1'b1;
                redirect_pc = mtvec_in;
                done_d      = 1'b1;
            end
            S_RET: begin
                redir_d     = 1'b1;
                redirect_pc = mepc_in;
                done_d      = 1'b1;
            end
            S_ILL: done_d = 1'b1;
            default: ;
        endcase
    end

    // An aborting reset must not let the current state's side effects land.
    assign csr_we         = csr_we_d  && !rst;
    assign gpr_wen        = gpr_wen_d && !rst;
    assign redirect_valid = redir_d   && !rst;
    assign done           = done_d    && !rst;

endmodule
